// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, field positions and decode helpers for decode_stage
package decode_pkg;

    localparam int IW   = 16;
    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int RW   = $clog2(NREG);

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef struct packed {
        logic [3:0]    op;
        logic [RW-1:0] rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic          regwrite;
        logic [DW-1:0] pc;
        logic          illegal;
    } idex_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_NOP);
    endfunction

    function automatic logic uses_rs1(input logic [3:0] op);
        return op <= OP_BEQ;
    endfunction

    // "rs2" here means whatever register sits on read port 2 (rd for ST/BEQ).
    function automatic logic uses_rs2(input logic [3:0] op);
        return (op <= OP_XOR) || (op == OP_ST) || (op == OP_BEQ);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_LD;
    endfunction

    function automatic logic sr2_sel(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - pending-write vector with set/clear/flush-clear and three queries
module decode_scoreboard
    import decode_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_valid_i,
    input  logic [RW-1:0] set_rd_i,
    input  logic          clr_valid_i,
    input  logic [RW-1:0] clr_rd_i,
    input  logic          flush_clr_valid_i,
    input  logic [RW-1:0] flush_clr_rd_i,
    input  logic [RW-1:0] q_src1_i,
    input  logic [RW-1:0] q_src2_i,
    input  logic [RW-1:0] q_dst_i,
    output logic          busy_src1_o,
    output logic          busy_src2_o,
    output logic          busy_dst_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Clears first so a same-cycle set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_rd_i] = 1'b0;
        end
        if (flush_clr_valid_i) begin
            pending_d[flush_clr_rd_i] = 1'b0;
        end
        if (set_valid_i) begin
            pending_d[set_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy_src1_o = pending_q[q_src1_i];
    assign busy_src2_o = pending_q[q_src2_i];
    assign busy_dst_o  = pending_q[q_dst_i];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with register-file read, hazard stall and ID/EX register
module decode_stage
    import decode_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [DW-1:0] in_pc,
    output logic [RW-1:0] sr1,
    output logic [RW-1:0] sr2,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] r2,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_imm,
    output logic          out_regwrite,
    output logic [DW-1:0] out_pc,
    output logic          out_illegal
);

    logic [3:0]    op_raw;
    logic          legal;
    logic [3:0]    op_eff;
    logic [RW-1:0] rd_f;
    logic [RW-1:0] rs1_f;
    logic [RW-1:0] rs2_f;
    logic          need_a;
    logic          need_b;
    logic          wr;
    logic          busy_a;
    logic          busy_b;
    logic          busy_d;
    logic          hazard;
    logic          issue;
    logic          out_valid_q;
    idex_t         out_q;

    assign op_raw = in_instr[OP_MSB:OP_LSB];
    assign legal  = is_legal(op_raw);
    // Undefined opcodes decode exactly like NOP: no reads, no write.
    assign op_eff = legal ? op_raw : OP_NOP;
    assign rd_f   = in_instr[RD_MSB:RD_LSB];
    assign rs1_f  = in_instr[RS1_MSB:RS1_LSB];
    assign rs2_f  = in_instr[RS2_MSB:RS2_LSB];
    assign need_a = uses_rs1(op_eff);
    assign need_b = uses_rs2(op_eff);
    assign wr     = writes_rd(op_eff);

    assign sr1 = rs1_f;
    assign sr2 = sr2_sel(op_eff) ? rd_f : rs2_f;

    decode_scoreboard u_sb (
        .clk               (clk),
        .rst_n             (rst_n),
        .set_valid_i       (issue && wr && (rd_f != '0)),
        .set_rd_i          (rd_f),
        .clr_valid_i       (wb_valid && (wb_rd != '0)),
        .clr_rd_i          (wb_rd),
        .flush_clr_valid_i (flush && out_valid_q && out_q.regwrite && (out_q.rd != '0)),
        .flush_clr_rd_i    (out_q.rd),
        .q_src1_i          (sr1),
        .q_src2_i          (sr2),
        .q_dst_i           (rd_f),
        .busy_src1_o       (busy_a),
        .busy_src2_o       (busy_b),
        .busy_dst_o        (busy_d)
    );

    assign hazard   = (need_a && busy_a) || (need_b && busy_b) || (wr && (rd_f != '0) && busy_d);
    assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (issue) begin
            out_valid_q    <= 1'b1;
            out_q.op       <= op_eff;
            out_q.rd       <= rd_f;
            out_q.a        <= r1;
            out_q.b        <= r2;
            out_q.imm      <= {{(DW-IMM_MSB-1){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:0]};
            out_q.regwrite <= wr;
            out_q.pc       <= in_pc;
            out_q.illegal  <= !legal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_op       = out_q.op;
    assign out_rd       = out_q.rd;
    assign out_a        = out_q.a;
    assign out_b        = out_q.b;
    assign out_imm      = out_q.imm;
    assign out_regwrite = out_q.regwrite;
    assign out_pc       = out_q.pc;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  in_pc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [7:0]  out_imm;
    logic        out_regwrite;
    logic [7:0]  out_pc;
    logic        out_illegal;

    logic [7:0]  rf [8];

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit done = 0;

    bit [7:0] m_pend = '0;
    bit       m_valid = 0;
    int       m_op = 0;
    int       m_rd = 0;
    int       m_a = 0;
    int       m_b = 0;
    int       m_imm = 0;
    int       m_rw = 0;
    int       m_pc = 0;
    int       m_ill = 0;
    bit       m_last_issue = 0;

    assign r1 = rf[sr1];
    assign r2 = rf[sr2];

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .sr1          (sr1),
        .sr2          (sr2),
        .r1           (r1),
        .r2           (r2),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_rd       (out_rd),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_imm      (out_imm),
        .out_regwrite (out_regwrite),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_r(input int op, input int rd, input int rs1, input int rs2);
        return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] mk_i(input int op, input int rd, input int rs1, input int imm);
        return {op[3:0], rd[2:0], rs1[2:0], imm[5:0]};
    endfunction

    function automatic int f_op(input logic [15:0] ins);
        return int'(ins[15:12]);
    endfunction

    function automatic int exp_sr2(input logic [15:0] ins);
        if (f_op(ins) == 7 || f_op(ins) == 8) return int'(ins[11:9]);
        return int'(ins[5:3]);
    endfunction

    function automatic bit model_hazard(input logic [15:0] ins, input bit [7:0] pend);
        int op  = f_op(ins);
        int rd  = int'(ins[11:9]);
        int rs1 = int'(ins[8:6]);
        int rs2 = int'(ins[5:3]);
        if (op <= 4) return pend[rs1] || pend[rs2] || (rd != 0 && pend[rd]);
        if (op <= 6) return pend[rs1] || (rd != 0 && pend[rd]);
        if (op <= 8) return pend[rs1] || pend[rd];
        return 0;
    endfunction

    function automatic bit model_ready();
        return rst_n && !flush && !model_hazard(in_instr, m_pend) && (!m_valid || out_ready);
    endfunction

    // Advance the model by one clock using the inputs seen at this edge.
    task automatic model_step();
        bit       issue;
        bit [7:0] np;
        int       op;
        int       imm;
        issue = in_valid && model_ready();
        m_last_issue = issue;
        np = m_pend;
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
            m_imm = 0; m_rw = 0; m_pc = 0; m_ill = 0;
            return;
        end
        if (wb_valid && wb_rd != 0) np[wb_rd] = 0;
        if (flush) begin
            if (m_valid && m_rw != 0 && m_rd != 0) np[m_rd] = 0;
            m_valid = 0;
        end else if (issue) begin
            op    = f_op(in_instr);
            m_ill = (op >= 10 && op <= 14) ? 1 : 0;
            m_op  = m_ill ? 15 : op;
            m_rd  = int'(in_instr[11:9]);
            m_a   = int'(rf[in_instr[8:6]]);
            m_b   = int'(rf[exp_sr2(in_instr)]);
            imm   = int'(in_instr[5:0]);
            if (imm >= 32) imm = imm - 64;
            m_imm = imm & 'hFF;
            m_rw  = (op <= 6) ? 1 : 0;
            m_pc  = int'(in_pc);
            m_valid = 1;
            if (m_rw != 0 && m_rd != 0) np[m_rd] = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        m_pend = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (started && !done) begin
            chk("in_ready", int'(in_ready), int'(model_ready()));
            chk("sr1", int'(sr1), int'(in_instr[8:6]));
            chk("sr2", int'(sr2), exp_sr2(in_instr));
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("out_op", int'(out_op), m_op);
            chk("out_rd", int'(out_rd), m_rd);
            chk("out_a", int'(out_a), m_a);
            chk("out_b", int'(out_b), m_b);
            chk("out_imm", int'(out_imm), m_imm);
            chk("out_regwrite", int'(out_regwrite), m_rw);
            chk("out_pc", int'(out_pc), m_pc);
            chk("out_illegal", int'(out_illegal), m_ill);
        end
    end

    initial begin
        rst_n = 0; in_valid = 1; in_instr = mk_r(0, 1, 2, 3); in_pc = 8'h10;
        wb_valid = 0; wb_rd = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        rf[2] = 8'h11; rf[3] = 8'h22;

        step(); started = 1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        step();
        rst_n = 1; #1;
        chk("post_reset_ready", int'(in_ready), 1);
        step();
        chk("add_valid", int'(out_valid), 1);
        chk("add_a", int'(out_a), 'h11);
        chk("add_b", int'(out_b), 'h22);
        chk("add_rd", int'(out_rd), 1);

        in_instr = mk_r(4, 4, 5, 6); in_pc = 8'h11; #1;
        chk("b2b_ready", int'(in_ready), 1);
        step();
        chk("xor_op", int'(out_op), 4);
        chk("xor_pc", int'(out_pc), 'h11);

        in_valid = 0; wb_valid = 1; wb_rd = 1; step();
        wb_rd = 4; step();
        wb_valid = 0;

        in_valid = 1; in_instr = mk_r(0, 3, 1, 2); step();
        in_instr = mk_r(1, 5, 3, 4); #1;
        chk("raw_stall", int'(in_ready), 0);
        step();
        chk("raw_hold", int'(in_ready), 0);
        step();
        wb_valid = 1; wb_rd = 3; rf[3] = 8'h5A; #1;
        chk("raw_no_bypass", int'(in_ready), 0);
        step();
        wb_valid = 0; #1;
        chk("raw_release", int'(in_ready), 1);
        step();
        chk("sub_op", int'(out_op), 1);
        chk("sub_a", int'(out_a), 'h5A);

        in_instr = mk_i(5, 0, 1, 'h3F); step();
        chk("addi_r0_imm", int'(out_imm), 'hFF);
        chk("addi_r0_rw", int'(out_regwrite), 1);
        chk("r0_not_pending", int'(in_ready), 1);
        in_instr = mk_i(5, 2, 1, 1); step();
        in_instr = mk_i(5, 2, 1, 2); #1;
        chk("waw_stall", int'(in_ready), 0);
        wb_valid = 1; wb_rd = 2; step();
        chk("waw_release", int'(in_ready), 1);
        step();
        wb_valid = 0; in_instr = mk_i(5, 3, 2, 0); #1;
        chk("set_wins", int'(in_ready), 0);
        wb_valid = 1; wb_rd = 2; step();
        wb_valid = 0; #1;
        chk("r2_cleared", int'(in_ready), 1);
        step();

        in_instr = mk_i(6, 6, 1, 0); in_pc = 8'h40; step();
        out_ready = 0; in_instr = mk_r(4, 1, 2, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_op", int'(out_op), 6);
            chk("bp_rd", int'(out_rd), 6);
            chk("bp_pc", int'(out_pc), 'h40);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_ready", int'(in_ready), 0);
        end
        flush = 1; step();
        flush = 0;
        chk("flush_valid", int'(out_valid), 0);
        in_instr = mk_i(5, 1, 6, 0); #1;
        chk("flush_clears_r6", int'(in_ready), 1);
        out_ready = 1; step();

        in_instr = mk_i(7, 7, 2, 5); #1;
        chk("st_sr1", int'(sr1), 2);
        chk("st_sr2", int'(sr2), 7);
        step();
        chk("st_rw", int'(out_regwrite), 0);
        chk("st_imm", int'(out_imm), 5);
        in_instr = mk_i('hC, 2, 0, 0); step();
        chk("ill_flag", int'(out_illegal), 1);
        chk("ill_rw", int'(out_regwrite), 0);
        in_instr = mk_i(5, 4, 2, 0); #1;
        chk("ill_no_set", int'(in_ready), 1);
        step();

        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || m_last_issue) begin
                in_valid = ($urandom % 4) != 0;
                in_instr = {4'($urandom_range(0, 15)), 12'($urandom)};
                in_pc = 8'($urandom);
            end
            wb_valid = ($urandom % 3) == 0;
            if (m_pend != 0 && ($urandom % 4) != 0) begin
                int k;
                k = $urandom % 8;
                while (!m_pend[k]) k = (k + 1) % 8;
                wb_rd = 3'(k);
            end else begin
                wb_rd = 3'($urandom);
            end
            if (wb_valid) rf[wb_rd] = 8'($urandom);
            flush = ($urandom % 20) == 0;
            out_ready = ($urandom % 10) < 7;
            rst_n = ($urandom % 100) != 0;
            step();
        end

        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
